// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the write port of an
// asynchronous FIFO among NREQ producers in the write-clock domain. One
// producer is granted for a burst of up to BURST words. Writes stall while
// the FIFO reports full, and a producer sees that stall as a missing ack.
module fifo_wr_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int BURST = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic                  wfull,
   output logic [NREQ-1:0]       ack,
   output logic [NREQ-1:0]       gnt,
   output logic                  winc,
   output logic [WIDTH-1:0]      wdata,
   output logic                  busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_n;
   logic [NREQ-1:0] gnt_q, gnt_n;
   logic [PW-1:0]   gidx_q, gidx_n;
   logic [PW-1:0]   ptr_q, ptr_n;
   logic [CW-1:0]   cnt_q, cnt_n;

   logic            sel_found;
   logic [PW-1:0]   sel_idx;
   logic [PW-1:0]   sel_next;
   logic            grant_ack;
   logic [WIDTH-1:0] word_arr [NREQ];

   // Indices are formed as base+offset with base, offset < NREQ, so one
   // conditional subtraction is enough to wrap them.
   function automatic logic [PW-1:0] wrap_idx(input int v);
      int r;
      r = (v >= NREQ) ? v - NREQ : v;
      return PW'(r);
   endfunction

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign word_arr[i] = req_data[i*WIDTH +: WIDTH];
   end

   // Round-robin search: walking offsets from high to low leaves the
   // closest requester at or above ptr as the final selection.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[wrap_idx(int'(ptr_q) + i)]) begin
            sel_found = 1'b1;
            sel_idx   = wrap_idx(int'(ptr_q) + i);
         end
      end
      sel_next = wrap_idx(int'(sel_idx) + 1);
   end

   // A word is accepted only when the granted producer offers one and the
   // FIFO has room.
   assign grant_ack = (state_q == GRANT) && req[gidx_q] && !wfull;

   // State register: grant, pointer and burst count; reset abandons any burst.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         gnt_q   <= gnt_n;
         gidx_q  <= gidx_n;
         ptr_q   <= ptr_n;
         cnt_q   <= cnt_n;
      end
   end

   // Next-state logic: grant from IDLE, release on a full burst or when the
   // producer withdraws while the FIFO is not full (a full FIFO hides it).
   always_comb begin
      state_n = state_q;
      gnt_n   = gnt_q;
      gidx_n  = gidx_q;
      ptr_n   = ptr_q;
      cnt_n   = cnt_q;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               state_n = GRANT;
               gnt_n   = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
               gidx_n  = sel_idx;
               ptr_n   = sel_next;
               cnt_n   = '0;
            end
         end
         GRANT: begin
            if (grant_ack) begin
               cnt_n = cnt_q + 1'b1;
               if (int'(cnt_q) + 1 >= BURST) begin
                  state_n = IDLE;
                  gnt_n   = '0;
               end
            end else if (!wfull && !req[gidx_q]) begin
               state_n = IDLE;
               gnt_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   // Outputs: ack/winc/wdata follow the granted producer combinationally,
   // and the data mux reads zero whenever nobody is granted.
   always_comb begin
      ack   = '0;
      winc  = 1'b0;
      wdata = '0;
      if (state_q == GRANT) begin
         ack[gidx_q] = grant_ack;
         winc        = grant_ack;
         wdata       = word_arr[gidx_q];
      end
   end

   assign gnt  = gnt_q;
   assign busy = (state_q == GRANT);

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the team's `asyn_fifo` between `NREQ` producers in the write-clock domain. Each producer offers words with a valid/ack handshake. The arbiter grants one producer at a time for a burst of up to `BURST` words and drives the FIFO `winc`/`wdata` directly. It never writes while `wfull` is high, so producers see back-pressure through `ack`.

## Interface
- `WIDTH`, 8: data word width; must match the FIFO `WIDTH`.
- `NREQ`, 4: number of requesters, 2..8.
- `BURST`, 4: maximum words accepted per grant, ≥1.

Ports:
- `clk`  in  1: write-side clock, the same clock as the FIFO `wclk`.
- `rstn`  in  1: asynchronous active-low reset.
- `req`  in  NREQ: per-requester valid. Producer holds its data stable until `ack`.
- `req_data`  in  NREQ*WIDTH: requester i data on bits [i*WIDTH +: WIDTH].
- `wfull`  in  1: FIFO full flag.
- `ack`  out  NREQ: one-hot pulse; requester i's current word was written this cycle.
- `gnt`  out  NREQ: registered one-hot grant, or all-zero.
- `winc`  out  1: FIFO write enable.
- `wdata`  out  WIDTH: FIFO write data.
- `busy`  out  1: registered; high while in GRANT.

## Operation
- States: IDLE and GRANT. Registers: `gnt`, round-robin pointer `ptr` (clog2(NREQ) bits), burst counter `cnt` (clog2(BURST+1) bits).
- IDLE:
  - If any `req` bit is set, select the first set bit searching from `ptr` upward, modulo NREQ.
  - Next cycle: `gnt` is set to that bit and the state is GRANT, `cnt`=0, `ptr` = selected+1 mod NREQ.
  - If no request, stay in IDLE.
- GRANT, granted index g:
  - `ack[g]` = `req[g]` & ~`wfull`. All other `ack` bits are 0.
  - `winc` = |`ack`. `wdata` = `req_data[g]` (combinational mux).
  - Each `ack` increments `cnt`.
- Release: from GRANT, go to IDLE on the first of these:
  - an `ack` that makes `cnt` reach BURST;
  - `req[g]`=0 in a GRANT cycle while `wfull`=0.
- On release: `gnt` clears next cycle and `busy` drops.
- `wfull`=1 in GRANT: stall. `winc`=0, `ack`=0, `cnt` holds, grant is kept even if `req[g]` drops during the stall.
- `req[g]`=0 while `wfull`=1: no release; the release check resumes when `wfull` falls.
- Requests arriving in GRANT are ignored until the next IDLE.
- Invariants:
  - `winc` is never high while `wfull` is high.
  - `ack` is at most one-hot and ⊆ `gnt`.
  - `winc` = |`ack`.
- Reset, asynchronous at any time including mid-burst:
  - state=IDLE, `gnt`=0, `busy`=0, `cnt`=0, `ptr`=0.
  - Hence `ack`=0, `winc`=0, `wdata`=0 (mux output forced to 0 when `gnt`=0).
  - A burst cut by reset is not resumed.

## Timing
- Grant latency: `req` rising at edge k (seen in IDLE) gives `gnt` high after edge k+1. The first possible `ack`/`winc` is in the cycle after edge k+1.
- Throughput: one word per cycle in GRANT when `wfull`=0.
- Arbitration gap: one IDLE cycle between grants. Sustained maximum is BURST words per BURST+1 cycles.
- `ack`/`winc`/`wdata` are combinational from `req`, `wfull` and registered `gnt`. The FIFO and producers sample them on the same `clk` edge.
- `gnt`, `busy`, `cnt`, `ptr` change only on `clk` edges or asynchronously on reset.

## Test plan
- Reset: assert `rstn`=0 mid-burst with `cnt`=2 → `gnt`=0, `winc`=0, `ack`=0, `busy`=0 immediately. After release, `req`=4'b1111 grants requester 0 first.
- Single producer, BURST=4: `req`=4'b0010 held for 6 words, `wfull`=0 → `gnt`=0010 one cycle after `req`. Four consecutive `ack[1]`/`winc` with `wdata` matching the offered words, then one cycle `gnt`=0, then regrant and 2 more words; FIFO holds all 6 in order.
- Fairness: `req`=4'b1111 held continuously → grant order 0,1,2,3,0, 4 words each. `winc` high 4 of every 5 cycles.
- Back-pressure: after 2 words of a burst, `wfull`=1 for 3 cycles → `winc`=0 and `ack`=0 for those 3 cycles, `cnt` stays 2, `gnt` unchanged. Then 2 more words and release; no write ever occurs with `wfull`=1.
- Early drop: requester 2 drops `req` after 1 acked word while `req[3]`=1 → release. `gnt` goes 0100 → 0000 → 1000.
- FIFO fill: single producer writes 16 words into a DEPTH=16 FIFO with the reader idle → exactly 16 `winc` pulses, `wfull` rises, and `ack` stays 0 until the reader drains a word.
